// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared definitions for the IF/ID, ID/EXE, EXE/MEM and MEM/WB
//                two-entry skid boundary registers: default payload width and
//                the occupancy-coded state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Default payload width carried across a pipeline boundary.
  localparam int DATA_W_DEF = 8;

  // Default width of the saturating flush-drop counter.
  localparam int CNT_W_DEF  = 8;

  // State encoding doubles as the occupancy count (number of held beats).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/if_id_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_skid_reg
//  Description : IF/ID boundary register. Two entries (main + skid) give full
//                throughput while in_ready comes straight from the state
//                flops. flush squashes held and incoming beats and a
//                saturating counter reports how many beats were discarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int SUM_W = CNT_W + 2;

  pipe_state_e        state_q, state_d;
  logic [DATA_W-1:0]  main_q,  main_d;
  logic [DATA_W-1:0]  skid_q,  skid_d;
  logic [CNT_W-1:0]   drop_q,  drop_d;

  logic               accept;
  logic               deliver;
  logic [SUM_W-1:0]   drop_sum;

  // All handshake outputs are decoded from the state flops only, so there is
  // no combinational path from out_ready to in_ready.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign drop_cnt  = drop_q;

  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;

  // Next state and data movement; flush overrides everything and leaves the
  // data registers untouched since they are don't-care once invalid.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = in_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && deliver) begin
          main_d  = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = ST_FULL;
        end else if (deliver) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only a delivery can move the state.
        if (deliver) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  // Drop accounting: beats lost on a flush are those held minus the one
  // delivered plus the one accepted. Summed two bits wider, then clamped.
  always_comb begin
    drop_d   = drop_q;
    drop_sum = {2'b00, drop_q}
             + {{CNT_W{1'b0}}, occupancy}
             + {{(CNT_W+1){1'b0}}, accept}
             - {{(CNT_W+1){1'b0}}, deliver};
    if (flush) begin
      if (drop_sum > {2'b00, {CNT_W{1'b1}}}) begin
        drop_d = {CNT_W{1'b1}};
      end else begin
        drop_d = drop_sum[CNT_W-1:0];
      end
    end
  end

  // State, payload and counter registers with asynchronous active-low reset.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      drop_q  <= drop_d;
    end
  end

endmodule : if_id_skid_reg
`default_nettype wire

// File: tb/tb_if_id_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_skid_reg
//  Description : Self-checking bench for if_id_skid_reg. Two instances share
//                stimulus: one with an 8-bit drop counter and one with a
//                2-bit drop counter to exercise saturation. A queue-based
//                FIFO model supplies every expected value.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_skid_reg;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       flush = 1'b0;

  logic       in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [7:0] out_data_a, out_data_b;
  logic [1:0] occ_a, occ_b;
  logic [7:0] drop_a;
  logic [1:0] drop_b;

  int n_total = 0;
  int n_bad   = 0;

  byte unsigned mq[$];
  int           m_drops = 0;
  int           obs_acc = 0;
  int           obs_del = 0;
  logic         hold_pend = 1'b0;
  logic [7:0]   hold_data = 8'h00;

  always #5 sysclk = ~sysclk;

  if_id_skid_reg #(.DATA_W(8), .CNT_W(8)) u_dut_a (
    .sysclk(sysclk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_a), .out_data(out_data_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .flush(flush), .occupancy(occ_a), .drop_cnt(drop_a)
  );

  if_id_skid_reg #(.DATA_W(8), .CNT_W(2)) u_dut_b (
    .sysclk(sysclk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_b), .out_data(out_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .flush(flush), .occupancy(occ_b), .drop_cnt(drop_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // Compare both instances against the model state for the current cycle.
  task automatic check_model();
    int n;
    n = mq.size();
    chk("occ_a",       occ_a,       n);
    chk("in_ready_a",  in_ready_a,  (n < 2));
    chk("out_valid_a", out_valid_a, (n > 0));
    chk("drop_a",      drop_a,      sat(m_drops, 255));
    chk("occ_b",       occ_b,       n);
    chk("in_ready_b",  in_ready_b,  (n < 2));
    chk("drop_b",      drop_b,      sat(m_drops, 3));
    if (n > 0) begin
      chk("out_data_a", out_data_a, mq[0]);
      chk("out_data_b", out_data_b, mq[0]);
    end
    if (hold_pend) chk("stable", out_data_a, hold_data);
  endtask

  // One clock: check at the falling edge, advance the model at the rising
  // edge, return just after it so the caller can drive the next inputs.
  task automatic cyc();
    bit acc, del;
    @(negedge sysclk);
    check_model();
    acc = in_valid && (mq.size() < 2);
    del = (mq.size() > 0) && out_ready;
    if (in_valid && in_ready_a) obs_acc++;
    if (out_valid_a && out_ready) obs_del++;
    hold_pend = out_valid_a && !out_ready && !flush;
    hold_data = out_data_a;
    @(posedge sysclk);
    if (flush) begin
      m_drops += mq.size() - int'(del) + int'(acc);
      mq.delete();
    end else begin
      if (del) void'(mq.pop_front());
      if (acc) mq.push_back(in_data);
    end
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    in_valid = 1'b1;
    in_data  = v;
    cyc();
    in_valid = 1'b0;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear with no edge.
  task automatic do_reset();
    in_valid  = 1'b0;
    flush     = 1'b0;
    @(posedge sysclk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid_a, 1'b0);
    chk("rst_in_ready",  in_ready_a,  1'b1);
    chk("rst_occ",       occ_a,       2'd0);
    chk("rst_drop_a",    drop_a,      8'd0);
    chk("rst_drop_b",    drop_b,      2'd0);
    chk("rst_out_data",  out_data_a,  8'h00);
    mq.delete();
    m_drops   = 0;
    obs_acc   = 0;
    obs_del   = 0;
    hold_pend = 1'b0;
    @(negedge sysclk);
    rst_n = 1'b1;
    @(posedge sysclk);
    #1;
  endtask

  initial begin : main
    logic [7:0] stream [3];
    logic [1:0] sat_exp [4];
    stream  = '{8'h11, 8'h22, 8'h33};
    sat_exp = '{2'd2, 2'd3, 2'd3, 2'd3};

    repeat (2) @(posedge sysclk);
    do_reset();

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(stream[i]);
      chk("stream_data",  out_data_a, stream[i]);
      chk("stream_ready", in_ready_a, 1'b1);
      chk("stream_occ",   occ_a,      2'd1);
    end
    repeat (2) cyc();

    // Backpressure fills the skid entry.
    out_ready = 1'b0;
    push(8'hA5);
    push(8'h5A);
    chk("bp_occ",   occ_a,      2'd2);
    chk("bp_ready", in_ready_a, 1'b0);
    chk("bp_data",  out_data_a, 8'hA5);
    cyc();
    chk("bp_hold",  out_data_a, 8'hA5);
    out_ready = 1'b1;
    cyc();
    chk("bp_drain_data",  out_data_a, 8'h5A);
    chk("bp_drain_ready", in_ready_a, 1'b1);
    cyc();
    chk("bp_empty", occ_a, 2'd0);

    // Flush from FULL, then flush in ONE with accept and deliver.
    out_ready = 1'b0;
    push(8'h01);
    push(8'h02);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("fl_occ",   occ_a,       2'd0);
    chk("fl_valid", out_valid_a, 1'b0);
    chk("fl_drop",  drop_a,      8'd2);
    push(8'h03);
    in_valid  = 1'b1;
    in_data   = 8'h04;
    out_ready = 1'b1;
    flush     = 1'b1;
    cyc();
    flush     = 1'b0;
    in_valid  = 1'b0;
    chk("fl_one_drop", drop_a, 8'd3);
    // Flush while empty and idle leaves the counter alone.
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("fl_idle_drop", drop_a, 8'd3);

    // Reset in the middle of a transfer.
    out_ready = 1'b0;
    push(8'h77);
    do_reset();

    // Saturation on the 2-bit counter instance.
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b0;
      push(8'(8'h40 + i));
      push(8'(8'h80 + i));
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("sat_drop_b", drop_b, sat_exp[i]);
      chk("sat_drop_a", drop_a, 8'(2 * (i + 1)));
    end

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = $urandom_range(1, 0) == 1;
      out_ready = $urandom_range(1, 0) == 1;
      flush     = $urandom_range(99, 0) < 5;
      in_data   = 8'($urandom);
      cyc();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    cyc();
    chk("accounting", obs_del + m_drops + int'(occ_a), obs_acc);
    out_ready = 1'b1;
    repeat (3) cyc();
    chk("final_empty", occ_a, 2'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_if_id_skid_reg
`default_nettype wire
